// File: rtl/ahfp_mul_arb.sv
// rtl/ahfp_mul_arb.sv - shares one pipelined FP multiplier among NREQ requesters with a latency-matched tag pipeline
// Build option: AHFP_MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module ahfp_mul_arb #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_dataa,
    input  logic [NREQ*32-1:0]   req_datab,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          mul_dataa,
    output logic [31:0]          mul_datab,
    input  logic [31:0]          mul_result,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 idle
);

    logic                      gnt_any;
    logic [ID_W-1:0]           gnt_id;
    logic [ID_W:0]             cand;
    logic                      iss_v;
    logic [ID_W-1:0]           iss_id;
    logic [MUL_LAT-1:0]        tag_v;
    logic [MUL_LAT*ID_W-1:0]   tag_id;

    assign gnt_any = |req;

`ifdef AHFP_MUL_ARB_FIXED_PRIO_EN
    // Scanning downward lets the lowest set index be the last assignment.
    always_comb begin
        gnt_id = '0;
        cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (ID_W+1)'(k);
            if (req[cand[ID_W-1:0]]) begin
                gnt_id = cand[ID_W-1:0];
            end
        end
    end
`else
    logic [ID_W-1:0] ptr;

    // Candidates ptr+NREQ down to ptr+1 (mod NREQ): the nearest successor of ptr wins.
    always_comb begin
        gnt_id = '0;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (req[cand[ID_W-1:0]]) begin
                gnt_id = cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NREQ - 1);
        end else if (gnt_any) begin
            ptr <= gnt_id;
        end
    end
`endif

    assign gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_dataa <= '0;
            mul_datab <= '0;
            iss_v     <= 1'b0;
            iss_id    <= '0;
        end else begin
            iss_v  <= gnt_any;
            iss_id <= gnt_id;
            if (gnt_any) begin
                mul_dataa <= req_dataa[{gnt_id, 5'd0} +: 32];
                mul_datab <= req_datab[{gnt_id, 5'd0} +: 32];
            end
        end
    end

    // Tags shift toward the MSB end; the top stage lines up with the multiplier output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= MUL_LAT'({tag_v, iss_v});
            tag_id <= (MUL_LAT*ID_W)'({tag_id, iss_id});
        end
    end

    assign rsp_valid  = tag_v[MUL_LAT-1];
    assign rsp_id     = tag_id[MUL_LAT*ID_W-1 -: ID_W];
    assign rsp_result = rsp_valid ? mul_result : 32'd0;
    assign idle       = ~iss_v & ~(|tag_v) & ~gnt_any;

endmodule

// File: tb/tb_ahfp_mul_arb.sv
// tb/tb_ahfp_mul_arb.sv - self-checking bench for ahfp_mul_arb with a cycle-schedule reference model
module tb_ahfp_mul_arb;

    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 6;
    localparam int DEPTH   = 4096;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*32-1:0]  req_dataa;
    logic [NREQ*32-1:0]  req_datab;
    logic [NREQ-1:0]     gnt;
    logic [31:0]         mul_dataa;
    logic [31:0]         mul_datab;
    logic [31:0]         mul_result;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_result;
    logic                idle;

    always #5 clk = ~clk;

    ahfp_mul_arb #(.NREQ(NREQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
        .gnt(gnt), .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .idle(idle)
    );

    // Truncating single-precision multiply for normal operands.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] man;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e   = e + 1;
            man = p[46:24];
        end else begin
            man = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], man};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(154, 100));
        return r;
    endfunction

    // Multiplier stand-in: no reset, MUL_LAT edges from sampling to result.
    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_dataa, mul_datab);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[MUL_LAT-1];

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          m_ptr;
    int          last_g;
    logic [31:0] m_a, m_b;
    bit          sv   [DEPTH];
    int          sid  [DEPTH];
    logic [31:0] sres [DEPTH];
    bit          hist [DEPTH];

    logic [NREQ-1:0] obs_gnt;
    logic            obs_rv, obs_idle;
    logic [ID_W-1:0] obs_rid;
    logic [31:0]     obs_rr, obs_a, obs_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef AHFP_MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_a    = '0;
        m_b    = '0;
        last_g = -1;
        for (int c = 0; c < DEPTH; c++) begin
            sv[c]   = 1'b0;
            hist[c] = 1'b0;
        end
    endtask

    // One clock: check at the falling edge, then fold the rising edge into the model.
    task automatic tick();
        int              g;
        bit              busy;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        g  = pick(req);
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        busy = 1'b0;
        for (int c = cyc - 1 - MUL_LAT; c <= cyc - 1; c++) if (c >= 0 && hist[c]) busy = 1'b1;
        obs_gnt = gnt; obs_rv = rsp_valid; obs_rid = rsp_id; obs_rr = rsp_result;
        obs_a = mul_dataa; obs_b = mul_datab; obs_idle = idle;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rsp_valid", 32'(rsp_valid), 32'(sv[cyc]));
        if (sv[cyc]) begin
            chk("rsp_id", 32'(rsp_id), 32'(sid[cyc]));
            chk("rsp_result", rsp_result, sres[cyc]);
        end else begin
            chk("rsp_result_gated", rsp_result, 32'd0);
        end
        chk("mul_dataa", mul_dataa, m_a);
        chk("mul_datab", mul_datab, m_b);
        chk("idle", 32'(idle), 32'(!busy && req == '0));
        @(posedge clk);
        last_g = -1;
        if (rst_n && g >= 0) begin
            last_g = g;
            m_ptr  = g;
            m_a    = req_dataa[g*32 +: 32];
            m_b    = req_datab[g*32 +: 32];
            hist[cyc] = 1'b1;
            if (cyc + 1 + MUL_LAT < DEPTH) begin
                sv[cyc + 1 + MUL_LAT]   = 1'b1;
                sid[cyc + 1 + MUL_LAT]  = g;
                sres[cyc + 1 + MUL_LAT] = fmul(m_a, m_b);
            end
        end
        #1;
        cyc++;
    endtask

    task automatic newop(input int i, input logic [31:0] a, input logic [31:0] b);
        req[i] = 1'b1;
        req_dataa[i*32 +: 32] = a;
        req_datab[i*32 +: 32] = b;
    endtask

    initial begin
        int nv, first_v, last_v;
        rst_n = 1'b0;
        req = '0;
        req_dataa = '0;
        req_datab = '0;
        model_reset();

        // Reset with no requests, then all four request together.
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_rsp_valid", 32'(obs_rv), 32'd0);
        chk("reset_rsp_result", obs_rr, 32'd0);
        chk("reset_mul_dataa", obs_a, 32'd0);
        chk("reset_idle", 32'(obs_idle), 32'd1);
        for (int i = 0; i < NREQ; i++) newop(i, rand_fp(), rand_fp());
        tick();
        chk("first_gnt", 32'(obs_gnt), 32'h1);
        req = '0;
        repeat (8) tick();

        // Single operation 2.0 * 3.0 from requester 2.
        newop(2, 32'h4000_0000, 32'h4040_0000);
        tick();
        chk("single_gnt", 32'(obs_gnt), 32'h4);
        req = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                chk("single_dataa", obs_a, 32'h4000_0000);
                chk("single_datab", obs_b, 32'h4040_0000);
            end
            if (k == 7) begin
                chk("single_rv", 32'(obs_rv), 32'd1);
                chk("single_rid", 32'(obs_rid), 32'd2);
                chk("single_result", obs_rr, 32'h40C0_0000);
            end else begin
                chk("single_rv_quiet", 32'(obs_rv), 32'd0);
            end
        end

`ifndef AHFP_MUL_ARB_FIXED_PRIO_EN
        // Full load: pointer sits at 2, so the rotation starts at 3.
        for (int i = 0; i < NREQ; i++) newop(i, rand_fp(), rand_fp());
        nv = 0; first_v = -1; last_v = -1;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k < 20) begin
                chk("rotate_gnt", 32'(obs_gnt), 32'(1) << ((3 + k) % NREQ));
                if (last_g >= 0) newop(last_g, rand_fp(), rand_fp());
                if (k == 19) req = '0;
            end
            if (obs_rv) begin
                nv++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
        end
        chk("load_rsp_count", 32'(nv), 32'd20);
        chk("load_rsp_first", 32'(first_v), 32'd7);
        chk("load_rsp_last", 32'(last_v), 32'd26);

        // Pointer skip: park ptr at 1, then 1010 grants 3 then 1, then 1 back-to-back.
        newop(1, rand_fp(), rand_fp());
        tick();
        chk("skip_park", 32'(obs_gnt), 32'h2);
        newop(1, rand_fp(), rand_fp());
        newop(3, rand_fp(), rand_fp());
        tick();
        chk("skip_first", 32'(obs_gnt), 32'h8);
        req[3] = 1'b0;
        tick();
        chk("skip_second", 32'(obs_gnt), 32'h2);
        newop(1, rand_fp(), rand_fp());
        tick();
        chk("skip_b2b", 32'(obs_gnt), 32'h2);
        req = '0;
        repeat (8) tick();
`else
        // Fixed priority: requester 0 always wins while it requests.
        for (int i = 0; i < NREQ; i++) newop(i, rand_fp(), rand_fp());
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fixed_gnt0", 32'(obs_gnt), 32'h1);
            newop(0, rand_fp(), rand_fp());
        end
        req[0] = 1'b0;
        tick();
        chk("fixed_gnt1", 32'(obs_gnt), 32'h2);
        req = '0;
        repeat (8) tick();
`endif

        // Reset two cycles after three grants: none of them may respond.
        newop(0, rand_fp(), rand_fp());
        tick();
        req[0] = 1'b0;
        newop(1, rand_fp(), rand_fp());
        tick();
        req[1] = 1'b0;
        newop(2, rand_fp(), rand_fp());
        tick();
        req = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("flush_rv", 32'(obs_rv), 32'd0);
            if (k == 0) chk("flush_idle", 32'(obs_idle), 32'd1);
        end
        newop(3, 32'h3FC0_0000, 32'h4000_0000);
        tick();
        req = '0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 7) begin
                chk("post_reset_rid", 32'(obs_rid), 32'd3);
                chk("post_reset_result", obs_rr, 32'h4040_0000);
            end
        end

        // Randomized traffic under the requester protocol.
        for (int k = 0; k < 400; k++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (i == last_g) begin
                    if ($urandom_range(1, 0) == 1) newop(i, rand_fp(), rand_fp());
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    newop(i, rand_fp(), rand_fp());
                end
            end
        end
        req = '0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
